// File: rtl/pla_pkg.sv
// Shared constants, default personality and plane-select type for the 4x4 PLA.
package pla_pkg;

  localparam int N_TERMS = 8;
  localparam int N_IN    = 4;
  localparam int N_OUT   = 4;
  localparam int ROW_W   = 8;

  typedef enum logic {
    SEL_AND = 1'b0,
    SEL_OR  = 1'b1
  } pla_sel_e;

  // Index 0 is the rightmost entry: P0=AB ... P7=B'D
  localparam logic [N_TERMS-1:0][ROW_W-1:0] DEF_AND = {
    8'h14, 8'hF0, 8'h0F, 8'h30, 8'h90, 8'h52, 8'h28, 8'hC0
  };

  // F1=AB+A'C, F2=BC'D+AD, F3=A'C+CD+B'D, F4=A'B'C'D'+ABCD
  localparam logic [N_OUT-1:0][N_TERMS-1:0] DEF_OR = {
    8'h60, 8'h92, 8'h0C, 8'h03
  };

endpackage

// File: rtl/pla_term.sv
// One product term: AND of the literals enabled by its 8-bit AND-plane row.
module pla_term
  import pla_pkg::*;
(
  input  logic [N_IN-1:0]  abcd,
  input  logic [ROW_W-1:0] row,
  output logic             term
);

  logic any_lit;
  logic true_ok;
  logic comp_ok;

  // abcd[3] is A so it lines up with row[7] (A) and row[3] (A')
  assign any_lit = |row;
  assign true_ok = &(abcd | ~row[7:4]);
  assign comp_ok = &(~abcd | ~row[3:0]);

  // An empty row is an unused term and must not read as constant 1
  assign term = any_lit & true_ok & comp_ok;

endmodule

// File: rtl/pla_4x4.sv
// Registered 4-input / 8-term / 4-output PLA with runtime-writable AND and OR planes.
module pla_4x4 #(
  parameter int N_TERMS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       cfg_we,
  input  logic       cfg_sel,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic       f1,
  output logic       f2,
  output logic       f3,
  output logic       f4
);

  import pla_pkg::*;

  pla_sel_e                              sel;
  logic [N_IN-1:0]                       abcd;
  logic [N_TERMS-1:0][ROW_W-1:0]         and_plane;
  logic [N_OUT-1:0][N_TERMS-1:0]         or_plane;
  logic [N_TERMS-1:0]                    terms;
  logic [N_OUT-1:0]                      f_next;
  logic [N_OUT-1:0]                      f_q;

  assign sel  = pla_sel_e'(cfg_sel);
  assign abcd = {a, b, c, d};

  for (genvar t = 0; t < N_TERMS; t++) begin : g_term
    pla_term u_term (
      .abcd (abcd),
      .row  (and_plane[t]),
      .term (terms[t])
    );
  end

  always_comb begin
    f_next = '0;
    for (int k = 0; k < N_OUT; k++) begin
      f_next[k] = |(or_plane[k] & terms);
    end
  end

  // Output capture and plane write share an edge, so the capture sees the old plane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      and_plane <= DEF_AND;
      or_plane  <= DEF_OR;
      f_q       <= '0;
    end else begin
      if (cfg_we) begin
        if (sel == SEL_AND) begin
          and_plane[cfg_addr] <= cfg_data;
        end else if (!cfg_addr[2]) begin
          or_plane[cfg_addr[1:0]] <= cfg_data;
        end
      end
      f_q <= f_next;
    end
  end

  assign f1 = f_q[0];
  assign f2 = f_q[1];
  assign f3 = f_q[2];
  assign f4 = f_q[3];

endmodule

// File: tb/tb_pla_4x4.sv
// Bench for pla_4x4: directed map checks plus randomized vectors/writes against a literal-level model.
module tb_pla_4x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b, c, d;
  logic       cfg_we;
  logic       cfg_sel;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       f1, f2, f3, f4;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_and [8];
  logic [7:0] m_or  [4];
  logic [3:0] m_exp;

  always #5 clk = ~clk;

  pla_4x4 dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .f1       (f1),
    .f2       (f2),
    .f3       (f3),
    .f4       (f4)
  );

  task automatic model_reset();
    m_and[0] = 8'hC0; m_and[1] = 8'h28; m_and[2] = 8'h52; m_and[3] = 8'h90;
    m_and[4] = 8'h30; m_and[5] = 8'h0F; m_and[6] = 8'hF0; m_and[7] = 8'h14;
    m_or[0]  = 8'h03; m_or[1]  = 8'h0C; m_or[2]  = 8'h92; m_or[3]  = 8'h60;
  endtask

  // Literal j: 0=A,1=B,2=C,3=D. A term is true only if it has a literal and none is violated.
  function automatic bit term_val(int t, logic [3:0] abcd);
    int lits = 0;
    bit ok = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bit v = abcd[3-j];
      if (m_and[t][7-j]) begin lits++; if (!v) ok = 1'b0; end
      if (m_and[t][3-j]) begin lits++; if (v)  ok = 1'b0; end
    end
    return (lits > 0) && ok;
  endfunction

  // Returned as {f1,f2,f3,f4}
  function automatic logic [3:0] model_eval(logic [3:0] abcd);
    logic [3:0] r = 4'b0000;
    for (int k = 0; k < 4; k++)
      for (int t = 0; t < 8; t++)
        if (m_or[k][t] && term_val(t, abcd)) r[3-k] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] obs();
    return {f1, f2, f3, f4};
  endfunction

  task automatic check(input string tag, input logic [3:0] expv);
    n_cmp++;
    assert (obs() === expv) else begin
      n_bad++;
      $error("FAIL %s: observed f1f2f3f4=%b expected %b", tag, obs(), expv);
    end
  endtask

  // One clock: drive at negedge, model captures with the old planes, then applies the write.
  task automatic step(input logic [3:0] abcd, input bit we, input bit sel,
                      input logic [2:0] addr, input logic [7:0] data, input string tag);
    @(negedge clk);
    {a, b, c, d} = abcd;
    cfg_we   = we;
    cfg_sel  = sel;
    cfg_addr = addr;
    cfg_data = data;
    m_exp = model_eval(abcd);
    if (we) begin
      if (!sel) m_and[addr] = data;
      else if (addr < 4) m_or[addr] = data;
    end
    @(posedge clk);
    #1;
    check(tag, m_exp);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [3:0] sweep_in  [6] = '{4'b0000, 4'b1100, 4'b0010, 4'b0001, 4'b1001, 4'b1111};
  logic [3:0] sweep_exp [6] = '{4'b0001, 4'b1000, 4'b1010, 4'b0010, 4'b0110, 4'b1111};

  initial begin
    rst = 1'b1;
    {a, b, c, d} = 4'b0000;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = 3'd0; cfg_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Default map sweep against hand-derived values
    for (int i = 0; i < 6; i++) begin
      step(sweep_in[i], 1'b0, 1'b0, 3'd0, 8'h00, "default_model");
      check($sformatf("default_%b", sweep_in[i]), sweep_exp[i]);
    end

    // Async reset between edges with ABCD=1111 already captured
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b1111, 1'b0, 1'b0, 3'd0, 8'h00, "post_reset_model");
    check("post_reset_1111", 4'b1111);

    // Reprogram F1 = P7 only; same-edge capture uses the old map
    step(4'b0001, 1'b1, 1'b1, 3'd0, 8'h80, "reprog_edge_model");
    check("reprog_same_edge", 4'b0010);
    step(4'b0001, 1'b0, 1'b0, 3'd0, 8'h00, "reprog_next_model");
    check("reprog_next_edge", 4'b1010);

    // Contradictory literal and empty row both kill P0
    do_reset();
    step(4'b1100, 1'b1, 1'b0, 3'd0, 8'h88, "p0_x_xbar_write");
    check("p0_write_edge_old", 4'b1000);
    step(4'b1100, 1'b0, 1'b0, 3'd0, 8'h00, "p0_x_xbar_model");
    check("p0_x_xbar", 4'b0000);
    step(4'b1100, 1'b1, 1'b0, 3'd0, 8'h00, "p0_empty_write");
    step(4'b1100, 1'b0, 1'b0, 3'd0, 8'h00, "p0_empty_model");
    check("p0_empty", 4'b0000);

    // Write during reset is dropped
    @(negedge clk);
    rst = 1'b1;
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h00;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    cfg_we = 1'b0;
    model_reset();
    step(4'b1100, 1'b0, 1'b0, 3'd0, 8'h00, "we_in_reset_model");
    check("we_in_reset", 4'b1000);

    // Out-of-range OR address is ignored; full sweep must match the default map
    step(4'b0000, 1'b1, 1'b1, 3'd5, 8'hFF, "or_addr5_write");
    for (int v = 0; v < 16; v++) begin
      logic [3:0] vv;
      vv = 4'(v);
      step(vv, 1'b0, 1'b0, 3'd0, 8'h00, $sformatf("ignored_wr_%b", vv));
    end

    // Random vectors with random legal writes
    for (int r = 0; r < 16; r++) begin
      logic [3:0] vv;
      bit         we, sel;
      logic [2:0] addr;
      vv   = 4'($urandom_range(0, 15));
      we   = 1'($urandom_range(0, 1));
      sel  = 1'($urandom_range(0, 1));
      addr = sel ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      step(vv, we, sel, addr, 8'($urandom), $sformatf("random_%0d", r));
    end
    // Drain: a few more evaluations with whatever personality the writes left
    for (int r = 0; r < 8; r++)
      step(4'($urandom_range(0, 15)), 1'b0, 1'b0, 3'd0, 8'h00, $sformatf("random_tail_%0d", r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
